// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble:
// one right shift of {S,A} plus a parallel per-digit -3 correction per clock.
module bcd2bin_seq #(
  parameter  int N = 8,
  localparam int W = N + (N - 4) / 3 + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_bcd,
  output logic [N-1:0] o_bin,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  localparam int DG = (W + 3) / 4;
  localparam int SW = 4 * DG;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_CHECK, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [SW-1:0]   r_s;
  logic [N-1:0]    r_a;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_bin;
  logic            r_err;

  logic [SW-1:0]   w_bcd_ext;
  logic            w_digits_ok;
  logic [SW+N-1:0] w_shifted;
  logic [SW-1:0]   w_s_next;
  logic [N-1:0]    w_a_next;

  assign w_bcd_ext = SW'(i_bcd);

  always_comb begin
    w_digits_ok = 1'b1;
    for (int k = 0; k < DG; k++) begin
      if (w_bcd_ext[4*k +: 4] > 4'd9) w_digits_ok = 1'b0;
    end
  end

  assign w_shifted = {r_s, r_a} >> 1;
  assign w_a_next  = w_shifted[N-1:0];

  // After the shift, a digit >= 8 received a carried-in half-ten; -3 restores BCD.
  always_comb begin
    w_s_next = '0;
    for (int k = 0; k < DG; k++) begin
      if (w_shifted[N+4*k +: 4] >= 4'd8) w_s_next[4*k +: 4] = w_shifted[N+4*k +: 4] - 4'd3;
      else                               w_s_next[4*k +: 4] = w_shifted[N+4*k +: 4];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: the next-state default is assigned first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = w_digits_ok ? S_CONV : S_CHECK;
      S_CONV:  if (r_cnt == CW'(N - 1)) w_state_next = S_CHECK;
      S_CHECK: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // A bad digit skips CONV; its non-zero S then fails the residual check below.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s   <= '0;
      r_a   <= '0;
      r_cnt <= '0;
      r_bin <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_s   <= w_bcd_ext;
            r_a   <= '0;
            r_cnt <= '0;
          end
        end
        S_CONV: begin
          r_s   <= w_s_next;
          r_a   <= w_a_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_CHECK: begin
          if (r_s != '0) begin
            r_bin <= '0;
            r_err <= 1'b1;
          end else begin
            r_bin <= r_a;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_bin  = r_bin;
  assign o_err  = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq (N=8): vector table, hand-written
// handshake/reset sequences, and random stimulus against a decimal model.
module tb_bcd2bin_seq;

  localparam int N = 8;
  localparam int W = 10;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic [W-1:0] i_bcd = '0;
  logic [N-1:0] o_bin;
  logic         o_busy;
  logic         o_done;
  logic         o_err;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] last_bin = '0;
  logic         last_err = 1'b0;

  bcd2bin_seq #(.N(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_bcd   (i_bcd),
    .o_bin   (o_bin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] bcd;
    logic [N-1:0] bin;
    logic         err;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Decimal reference: digits > 9 are invalid, values above 2^N-1 overflow.
  function automatic void model(input logic [W-1:0] bcd, output logic [N-1:0] bin,
                                output logic err, output int lat);
    int d0, d1, d2, v;
    d0 = int'(bcd[3:0]);
    d1 = int'(bcd[7:4]);
    d2 = int'(bcd[9:8]);
    if (d0 > 9 || d1 > 9 || d2 > 9) begin
      bin = '0; err = 1'b1; lat = 1;
    end else begin
      v = d2 * 100 + d1 * 10 + d0;
      lat = N + 1;
      if (v > (1 << N) - 1) begin
        bin = '0; err = 1'b1;
      end else begin
        bin = N'(v); err = 1'b0;
      end
    end
  endfunction

  // One conversion; index 0 is the cycle right after the accepting edge.
  // poke >= 0 pulses START with poke_bcd at that index (must be ignored).
  task automatic run(input string tag, input logic [W-1:0] bcd, input logic [N-1:0] exp_bin,
                     input logic exp_err, input int exp_lat, input int poke,
                     input logic [W-1:0] poke_bcd);
    int idx, busy_cnt;
    bit hold_ok;
    @(negedge i_clk);
    i_bcd = bcd;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_bcd = W'($urandom);
    idx = 0; busy_cnt = 0; hold_ok = 1'b1;
    while (1) begin
      if (o_busy) busy_cnt++;
      if (o_done) break;
      if (o_bin !== last_bin || o_err !== last_err) hold_ok = 1'b0;
      if (idx >= 40) break;
      i_start = (idx == poke);
      i_bcd = (idx == poke) ? poke_bcd : W'($urandom);
      @(negedge i_clk);
      idx++;
    end
    i_start = (idx == poke);
    i_bcd = poke_bcd;
    check({tag, " latency"}, idx, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat + 1);
    check({tag, " bin"}, o_bin, exp_bin);
    check({tag, " err"}, o_err, exp_err);
    check({tag, " bin_held"}, hold_ok, 1);
    last_bin = exp_bin;
    last_err = exp_err;
    @(negedge i_clk);
    i_start = 1'b0;
    check({tag, " done_pulse"}, o_done, 0);
    check({tag, " idle_busy"}, o_busy, 0);
    @(negedge i_clk);
    check({tag, " still_idle"}, o_busy, 0);
  endtask

  initial begin
    vec_t vecs[11];
    int done_idx[$];
    logic [N-1:0] m_bin;
    logic         m_err;
    int           m_lat;
    logic [W-1:0] r_bcd;

    vecs[0]  = '{10'h255, 8'hFF, 1'b0, N + 1};
    vecs[1]  = '{10'h000, 8'h00, 1'b0, N + 1};
    vecs[2]  = '{10'h128, 8'h80, 1'b0, N + 1};
    vecs[3]  = '{10'h256, 8'h00, 1'b1, N + 1};
    vecs[4]  = '{10'h1A3, 8'h00, 1'b1, 1};
    vecs[5]  = '{10'h2A0, 8'h00, 1'b1, 1};
    vecs[6]  = '{10'h299, 8'h00, 1'b1, N + 1};
    vecs[7]  = '{10'h200, 8'hC8, 1'b0, N + 1};
    vecs[8]  = '{10'h00A, 8'h00, 1'b1, 1};
    vecs[9]  = '{10'h3FF, 8'h00, 1'b1, 1};
    vecs[10] = '{10'h099, 8'h63, 1'b0, N + 1};

    #1;
    check("reset busy", o_busy, 0);
    check("reset done", o_done, 0);
    check("reset bin", o_bin, 0);
    check("reset err", o_err, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].bin, vecs[i].err,
                          vecs[i].lat, -1, '0);

    // START mid-CONV and START during the DONE cycle are both ignored.
    run("poke_mid", 10'h099, 8'h63, 1'b0, N + 1, 3, 10'h200);
    run("poke_done", 10'h042, 8'h2A, 1'b0, N + 1, N + 1, 10'h255);

    // Asynchronous reset in the middle of CONV.
    @(negedge i_clk);
    i_bcd = 10'h255;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("abort busy", o_busy, 0);
    check("abort done", o_done, 0);
    check("abort bin", o_bin, 0);
    check("abort err", o_err, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    last_bin = '0;
    last_err = 1'b0;
    begin
      bit quiet = 1'b1;
      for (int c = 0; c < 15; c++) begin
        @(negedge i_clk);
        if (o_done || o_busy) quiet = 1'b0;
      end
      check("abort no_done", quiet, 1);
    end
    run("after_abort", 10'h042, 8'h2A, 1'b0, N + 1, -1, '0);

    // START held high: accepted again every N+3 cycles.
    @(negedge i_clk);
    i_bcd = 10'h042;
    i_start = 1'b1;
    for (int c = 0; c < 40 && done_idx.size() < 2; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        done_idx.push_back(c);
        check("held bin", o_bin, 8'h2A);
      end
    end
    i_start = 1'b0;
    check("held done_count", done_idx.size(), 2);
    if (done_idx.size() == 2) check("held period", done_idx[1] - done_idx[0], N + 3);
    for (int c = 0; c < 20 && o_busy; c++) @(negedge i_clk);
    @(negedge i_clk);
    check("held drained", o_busy, 0);
    last_bin = 8'h2A;
    last_err = 1'b0;

    // Random stimulus against the decimal model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r_bcd = W'($urandom);
      end else begin
        r_bcd[9:8] = 2'($urandom_range(0, 2));
        r_bcd[7:4] = 4'($urandom_range(0, 9));
        r_bcd[3:0] = 4'($urandom_range(0, 9));
      end
      model(r_bcd, m_bin, m_err, m_lat);
      run($sformatf("rnd%0d_%03h", i, r_bcd), r_bcd, m_bin, m_err, m_lat,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N + 1)) : -1, W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
